// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream width converters.
package stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ds_state_t;

    // Bits needed to index a lane; never less than one so ports stay legal.
    function automatic int unsigned LANE_W(input int unsigned ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/stream_lane_pick.sv
// Lowest-set-bit picker over the remaining-lane mask: index, one-hot and "last one left".
module stream_lane_pick
    import stream_pkg::*;
#(
    parameter int unsigned RATIO = 2,
    localparam int unsigned LW = LANE_W(RATIO)
) (
    input  logic [RATIO-1:0] rem,
    output logic [LW-1:0]    lane_c,
    output logic [RATIO-1:0] onehot_c,
    output logic             is_final_c
);

    // Two's-complement trick isolates the lowest set bit.
    assign onehot_c   = rem & (~rem + RATIO'(1));
    assign is_final_c = (rem != '0) && ((rem & (rem - RATIO'(1))) == '0);

    always_comb begin
        lane_c = '0;
        for (int i = 0; i < int'(RATIO); i++) begin
            if (onehot_c[i]) begin
                lane_c = LW'(i);
            end
        end
    end

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow serializer: emits the kept lanes of each input word, one per beat, lowest lane first.
module stream_downsize
    import stream_pkg::*;
#(
    parameter int unsigned T_DATA_WIDTH = 1,
    parameter int unsigned T_DATA_RATIO = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [T_DATA_WIDTH-1:0] s_data_i [0:T_DATA_RATIO-1],
    input  logic [T_DATA_RATIO-1:0] s_keep_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic                    drop_o
);

    localparam int unsigned LW = LANE_W(T_DATA_RATIO);

    ds_state_t               state_q, state_d;
    logic [T_DATA_WIDTH-1:0] buf_q [0:T_DATA_RATIO-1];
    logic [T_DATA_RATIO-1:0] rem_q, rem_d;
    logic                    last_q;
    logic                    drop_q, drop_d;
    logic                    load;

    logic [LW-1:0]           lane;
    logic [T_DATA_RATIO-1:0] lane_onehot;
    logic                    is_final;
    logic                    beat_hs;
    logic                    accept;

    stream_lane_pick #(
        .RATIO (T_DATA_RATIO)
    ) u_pick (
        .rem        (rem_q),
        .lane_c     (lane),
        .onehot_c   (lane_onehot),
        .is_final_c (is_final)
    );

    assign m_valid_o = (state_q == SEND);
    assign m_data_o  = buf_q[lane];
    assign m_last_o  = last_q & is_final & m_valid_o;
    assign drop_o    = drop_q;

    // A new word may enter in the same cycle the last kept lane leaves.
    assign beat_hs   = m_valid_o & m_ready_i;
    assign s_ready_o = !rst & ((state_q == IDLE) | (beat_hs & is_final));
    assign accept    = s_valid_i & s_ready_o;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        drop_d  = 1'b0;
        load    = 1'b0;

        if (beat_hs) begin
            rem_d = rem_q & ~lane_onehot;
            if (is_final) begin
                state_d = IDLE;
            end
        end

        if (accept) begin
            if (s_keep_i != '0) begin
                load    = 1'b1;
                rem_d   = s_keep_i;
                state_d = SEND;
            end else begin
                drop_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            last_q  <= 1'b0;
            drop_q  <= 1'b0;
            for (int i = 0; i < int'(T_DATA_RATIO); i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            drop_q  <= drop_d;
            if (load) begin
                buf_q  <= s_data_i;
                last_q <= s_last_i;
            end
        end
    end

endmodule
